// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC and a loadable instruction memory,
// issues {instrCode, PC} to IF/ID with combinational flush and halt parking.
module instr_fetch_unit #(
  parameter int         MEM_DEPTH = 16,
  parameter logic [7:0] HALT_OP   = 8'hFF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load_en,
  input  logic       imem_we,
  input  logic [7:0] imem_waddr,
  input  logic [7:0] imem_wdata,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  output logic [7:0] instrCode,
  output logic [7:0] PC,
  output logic       flush,
  output logic       halted,
  output logic [7:0] fetch_count
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] pc_reg, pc_next;
  logic [7:0] count_reg, count_next, count_inc;
  logic [7:0] rd_word;
  logic       wr_ok;
  logic       pc_in_range;
  logic [7:0] mem_rd [MEM_DEPTH];

  assign wr_ok = (state_reg == ST_LOAD) && imem_we;

  // Word registers rather than RAM: reset has to clear every location at once.
  // Addresses at or above MEM_DEPTH match no word, so those writes vanish.
  generate
    for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
      localparam logic [7:0] WORD_ADDR = 8'(gi);
      logic [7:0] word_reg;

      always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
          word_reg <= 8'h00;
        end else if (wr_ok && (imem_waddr == WORD_ADDR)) begin
          word_reg <= imem_wdata;
        end
      end

      assign mem_rd[gi] = word_reg;
    end
  endgenerate

  assign pc_in_range = (int'(pc_reg) < MEM_DEPTH);

  always_comb begin
    rd_word = 8'h00;
    if ((state_reg == ST_RUN) && pc_in_range) begin
      rd_word = mem_rd[pc_reg[AW-1:0]];
    end
  end

  assign count_inc = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= ST_LOAD;
      pc_reg    <= 8'h00;
      count_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    count_next = count_reg;
    flush      = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        pc_next = 8'h00;
        if (!load_en) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        flush = branch_taken;
        if (branch_taken) begin
          pc_next = branch_target;
        end else if (stall) begin
          pc_next = pc_reg;
        end else if (rd_word == HALT_OP) begin
          state_next = ST_HALT;
          count_next = count_inc;
        end else begin
          pc_next    = pc_reg + 8'd1;
          count_next = count_inc;
        end
      end
      ST_HALT: begin
        flush = branch_taken;
        if (branch_taken) begin
          pc_next    = branch_target;
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_LOAD;
        pc_next    = 8'h00;
      end
    endcase
  end

  assign instrCode   = rd_word;
  assign PC          = pc_reg;
  assign halted      = (state_reg == ST_HALT);
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized run-time
// traffic, all checked against a behavioural fetch model held in the bench.
module tb_instr_fetch_unit;

  localparam int DEPTH = 16;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       load_en;
  logic       imem_we;
  logic [7:0] imem_waddr;
  logic [7:0] imem_wdata;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] instrCode;
  logic [7:0] PC;
  logic       flush;
  logic       halted;
  logic [7:0] fetch_count;

  int total = 0;
  int bad   = 0;

  // Reference model: program contents, fetch address, issue count, mode flags.
  logic [7:0] m_mem [DEPTH];
  int         m_pc;
  int         m_cnt;
  bit         m_loading;
  bit         m_halted;

  instr_fetch_unit #(.MEM_DEPTH(DEPTH), .HALT_OP(8'hFF)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .load_en       (load_en),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instrCode     (instrCode),
    .PC            (PC),
    .flush         (flush),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] exp_instr();
    if (m_loading || m_halted || m_pc >= DEPTH) return 8'h00;
    return m_mem[m_pc];
  endfunction

  function automatic logic exp_flush();
    return !m_loading && branch_taken;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_pc      = 0;
    m_cnt     = 0;
    m_loading = 1'b1;
    m_halted  = 1'b0;
  endtask

  task automatic model_edge();
    logic [7:0] cur;
    cur = exp_instr();
    if (m_loading) begin
      if (imem_we && imem_waddr < DEPTH) m_mem[imem_waddr] = imem_wdata;
      if (!load_en) m_loading = 1'b0;
    end else if (m_halted) begin
      if (branch_taken) begin
        m_pc     = branch_target;
        m_halted = 1'b0;
      end
    end else if (branch_taken) begin
      m_pc = branch_target;
    end else if (!stall) begin
      if (m_cnt < 255) m_cnt = m_cnt + 1;
      if (cur == 8'hFF) m_halted = 1'b1;
      else m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic idle_inputs();
    imem_we       = 1'b0;
    imem_waddr    = 8'h00;
    imem_wdata    = 8'h00;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
  endtask

  task automatic clk_edge();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset   = 1'b0;
    load_en = 1'b1;
    idle_inputs();
    #1;
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic load_write(input logic [7:0] addr, input logic [7:0] data);
    load_en    = 1'b1;
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    clk_edge();
    imem_we = 1'b0;
  endtask

  task automatic leave_load();
    load_en = 1'b0;
    clk_edge();
  endtask

  task automatic test_reset();
    Reset        = 1'b0;
    load_en      = 1'b1;
    idle_inputs();
    branch_taken = 1'b1;
    stall        = 1'b1;
    #1;
    model_reset();
    total++;
    if (PC !== 8'h00 || instrCode !== 8'h00 || flush !== 1'b0 || halted !== 1'b0 ||
        fetch_count !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: got pc=%h instr=%h flush=%b halted=%b cnt=%h want all zero",
               PC, instrCode, flush, halted, fetch_count);
    end
    @(negedge Clk);
    Reset = 1'b1;
    clk_edge();
    #1;
    total++;
    if (PC !== 8'h00 || flush !== 1'b0 || instrCode !== 8'h00) begin
      bad++;
      $display("FAIL load_ignores_ctrl: got pc=%h flush=%b instr=%h want 00/0/00",
               PC, flush, instrCode);
    end
    idle_inputs();
  endtask

  task automatic test_load_run();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    load_write(8'd0, 8'h11);
    load_write(8'd1, 8'h22);
    load_write(8'd2, 8'h33);
    // last write shares the edge that leaves LOAD
    imem_we    = 1'b1;
    imem_waddr = 8'd3;
    imem_wdata = 8'h44;
    load_en    = 1'b0;
    clk_edge();
    imem_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (PC !== 8'(k) || instrCode !== vals[k]) begin
        bad++;
        $display("FAIL load_run[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                 k, PC, instrCode, 8'(k), vals[k]);
      end
      clk_edge();
    end
    #1;
    total++;
    if (fetch_count !== 8'd4 || PC !== 8'd4 || instrCode !== 8'h00) begin
      bad++;
      $display("FAIL load_run_count: got cnt=%h pc=%h instr=%h want 04/04/00",
               fetch_count, PC, instrCode);
    end
  endtask

  task automatic test_branch();
    branch_taken  = 1'b1;
    branch_target = 8'd2;
    #1;
    total++;
    if (flush !== 1'b1) begin
      bad++;
      $display("FAIL branch_flush_a: got %b want 1", flush);
    end
    clk_edge();
    branch_taken = 1'b0;
    #1;
    total++;
    if (PC !== 8'd2 || instrCode !== 8'h33 || fetch_count !== 8'd4) begin
      bad++;
      $display("FAIL branch_to_2: got pc=%h instr=%h cnt=%h want 02/33/04",
               PC, instrCode, fetch_count);
    end
    branch_taken  = 1'b1;
    branch_target = 8'd0;
    #1;
    total++;
    if (flush !== 1'b1) begin
      bad++;
      $display("FAIL branch_flush_b: got %b want 1", flush);
    end
    clk_edge();
    branch_taken = 1'b0;
    #1;
    total++;
    if (PC !== 8'd0 || instrCode !== 8'h11 || flush !== 1'b0) begin
      bad++;
      $display("FAIL branch_to_0: got pc=%h instr=%h flush=%b want 00/11/0",
               PC, instrCode, flush);
    end
  endtask

  task automatic test_stall();
    clk_edge();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (PC !== 8'd1 || instrCode !== 8'h22 || fetch_count !== 8'd5) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got pc=%h instr=%h cnt=%h want 01/22/05",
                 k, PC, instrCode, fetch_count);
      end
      clk_edge();
    end
    branch_taken  = 1'b1;
    branch_target = 8'd3;
    #1;
    total++;
    if (flush !== 1'b1) begin
      bad++;
      $display("FAIL stall_branch_flush: got %b want 1", flush);
    end
    clk_edge();
    stall        = 1'b0;
    branch_taken = 1'b0;
    #1;
    total++;
    if (PC !== 8'd3 || instrCode !== 8'h44) begin
      bad++;
      $display("FAIL stall_branch_prio: got pc=%h instr=%h want 03/44", PC, instrCode);
    end
    clk_edge();
    #1;
    total++;
    if (PC !== 8'd4 || fetch_count !== 8'd6) begin
      bad++;
      $display("FAIL stall_resume: got pc=%h cnt=%h want 04/06", PC, fetch_count);
    end
  endtask

  task automatic test_halt();
    do_reset();
    load_write(8'd0, 8'h11);
    load_write(8'd1, 8'h22);
    load_write(8'd2, 8'hFF);
    leave_load();
    clk_edge();
    clk_edge();
    #1;
    total++;
    if (PC !== 8'd2 || instrCode !== 8'hFF || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_issue: got pc=%h instr=%h halted=%b want 02/ff/0",
               PC, instrCode, halted);
    end
    clk_edge();
    for (int k = 0; k < 10; k++) begin
      stall = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (halted !== 1'b1 || instrCode !== 8'h00 || PC !== 8'd2 || fetch_count !== 8'd3) begin
        bad++;
        $display("FAIL halt_park[%0d]: got halted=%b instr=%h pc=%h cnt=%h want 1/00/02/03",
                 k, halted, instrCode, PC, fetch_count);
      end
      clk_edge();
    end
    stall         = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 8'd0;
    #1;
    total++;
    if (flush !== 1'b1) begin
      bad++;
      $display("FAIL halt_exit_flush: got %b want 1", flush);
    end
    clk_edge();
    branch_taken = 1'b0;
    #1;
    total++;
    if (halted !== 1'b0 || PC !== 8'd0 || instrCode !== 8'h11) begin
      bad++;
      $display("FAIL halt_exit: got halted=%b pc=%h instr=%h want 0/00/11",
               halted, PC, instrCode);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] exp_pc [3];
    exp_pc = '{8'hFE, 8'hFF, 8'h00};
    do_reset();
    load_write(8'h00, 8'h77);
    load_write(8'h20, 8'h5A);
    load_write(8'h10, 8'h66);
    leave_load();
    #1;
    total++;
    if (PC !== 8'h00 || instrCode !== 8'h77) begin
      bad++;
      $display("FAIL oob_write_dropped: got pc=%h instr=%h want 00/77", PC, instrCode);
    end
    branch_taken  = 1'b1;
    branch_target = 8'hFE;
    clk_edge();
    branch_taken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (PC !== exp_pc[k] || instrCode !== exp_instr() || fetch_count !== 8'(m_cnt)) begin
        bad++;
        $display("FAIL pc_wrap[%0d]: got pc=%h instr=%h cnt=%h want pc=%h instr=%h cnt=%h",
                 k, PC, instrCode, fetch_count, exp_pc[k], exp_instr(), 8'(m_cnt));
      end
      clk_edge();
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 300; k++) begin
      #1;
      total++;
      if (fetch_count !== 8'(m_cnt) || PC !== 8'(m_pc)) begin
        bad++;
        $display("FAIL saturate[%0d]: got cnt=%h pc=%h want cnt=%h pc=%h",
                 k, fetch_count, PC, 8'(m_cnt), 8'(m_pc));
      end
      clk_edge();
    end
    #1;
    total++;
    if (fetch_count !== 8'd255) begin
      bad++;
      $display("FAIL saturate_final: got %h want ff", fetch_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 24; k++) begin
      load_write(8'($urandom_range(0, 31)),
                 ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom));
    end
    leave_load();
    for (int k = 0; k < 500; k++) begin
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_target = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
      imem_we       = 1'($urandom_range(0, 1));
      imem_waddr    = 8'($urandom_range(0, 15));
      imem_wdata    = 8'($urandom);
      load_en       = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (instrCode !== exp_instr() || PC !== 8'(m_pc) || flush !== exp_flush() ||
          halted !== m_halted || fetch_count !== 8'(m_cnt)) begin
        bad++;
        $display("FAIL random[%0d]: got i=%h pc=%h f=%b h=%b c=%h want i=%h pc=%h f=%b h=%b c=%h",
                 k, instrCode, PC, flush, halted, fetch_count,
                 exp_instr(), 8'(m_pc), exp_flush(), m_halted, 8'(m_cnt));
      end
      clk_edge();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 8; k++) load_write(8'(k), 8'h30 + 8'(k));
    leave_load();
    for (int k = 0; k < 5; k++) clk_edge();
    #1;
    total++;
    if (PC !== 8'd5 || instrCode !== 8'h35) begin
      bad++;
      $display("FAIL pre_reset_pc: got pc=%h instr=%h want 05/35", PC, instrCode);
    end
    #2;
    Reset   = 1'b0;
    load_en = 1'b1;
    #1;
    model_reset();
    total++;
    if (PC !== 8'h00 || instrCode !== 8'h00 || halted !== 1'b0 || fetch_count !== 8'h00) begin
      bad++;
      $display("FAIL async_reset: got pc=%h instr=%h halted=%b cnt=%h want 00/00/0/00",
               PC, instrCode, halted, fetch_count);
    end
    @(negedge Clk);
    Reset = 1'b1;
    leave_load();
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (PC !== 8'(k) || instrCode !== 8'h00) begin
        bad++;
        $display("FAIL mem_cleared[%0d]: got pc=%h instr=%h want pc=%h instr=00",
                 k, PC, instrCode, 8'(k));
      end
      clk_edge();
    end
  endtask

  initial begin
    Reset   = 1'b0;
    load_en = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge Clk);
    test_reset();
    test_load_run();
    test_branch();
    test_stall();
    test_halt();
    test_boundary();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
